window_fetch_ctrl: RTL and testbench

Producer side of the window-buffer read/shift interface. It fetches image pixels from the frame SRAM and presents them one at a time (data_r, slot, start_read) to the 3x3 window buffer. It commands left shifts (start_shift, shift_direc) to advance the window across a row, and reloads all 9 pixels at each new row. It flags each completed window to the Sobel datapath and waits for an acknowledge before advancing.

---
 rtl/window_fetch_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_window_fetch_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_fetch_ctrl.sv
// Fetches 3x3 pixel windows from the frame SRAM into the window buffer, shifting left
// along a row and reloading all nine slots at the start of each new row.
module window_fetch_ctrl #(
  parameter int IMG_W     = 8,
  parameter int IMG_H     = 8,
  parameter int ADDR_W    = 16,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [7:0]        mem_rdata,
  output logic              start_read,
  output logic [7:0]        data_r,
  output logic [3:0]        slot,
  input  logic              read_done,
  output logic              start_shift,
  output logic [1:0]        shift_direc,
  input  logic              shift_done,
  output logic              window_valid,
  input  logic              window_ack,
  output logic              busy,
  output logic              frame_done
);

  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MREQ,
    S_WBWR,
    S_WVALID,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [ROW_W-1:0]  r_row;
  logic [COL_W-1:0]  r_col;
  logic [3:0]        r_pix;
  logic              r_full;
  logic              r_mem_req;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_start_read;
  logic [7:0]        r_data_r;
  logic [3:0]        r_slot;
  logic              r_start_shift;
  logic [1:0]        r_shift_direc;
  logic              r_window_valid;
  logic              r_busy;
  logic              r_frame_done;

  // Load-order tables indexed by pixel counter: row offset, column offset, slot.
  logic [1:0] w_full_dr   [16];
  logic [1:0] w_full_dc   [16];
  logic [3:0] w_full_slot [16];
  logic [1:0] w_col_dr    [16];
  logic [1:0] w_col_dc    [16];
  logic [3:0] w_col_slot  [16];

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_tab
      if (gi < 9) begin : g_full
        assign w_full_dr[gi]   = 2'(2 - gi / 3);
        assign w_full_dc[gi]   = 2'(gi % 3);
        assign w_full_slot[gi] = 4'(3 * (2 - gi / 3) + gi % 3);
      end else begin : g_full_pad
        assign w_full_dr[gi]   = '0;
        assign w_full_dc[gi]   = '0;
        assign w_full_slot[gi] = '0;
      end
      if (gi < 3) begin : g_col
        assign w_col_dr[gi]   = 2'(2 - gi);
        assign w_col_dc[gi]   = 2'd2;
        assign w_col_slot[gi] = 4'(3 * (2 - gi) + 2);
      end else begin : g_col_pad
        assign w_col_dr[gi]   = '0;
        assign w_col_dc[gi]   = '0;
        assign w_col_slot[gi] = '0;
      end
    end
  endgenerate

  logic [ROW_W-1:0]  w_ld_row;
  logic [COL_W-1:0]  w_ld_col;
  logic [3:0]        w_ld_pix;
  logic              w_ld_full;
  logic [1:0]        w_ld_dr;
  logic [1:0]        w_ld_dc;
  logic [ADDR_W-1:0] w_ld_addr;
  logic [3:0]        w_cur_slot;
  logic              w_last_pix;
  logic              w_last_col;
  logic              w_last_row;

  // Coordinates of the next pixel to request, chosen by which transition will launch it.
  always_comb begin
    w_ld_row  = r_row;
    w_ld_col  = r_col;
    w_ld_full = r_full;
    w_ld_pix  = r_pix + 4'd1;
    case (r_state)
      S_IDLE: begin
        w_ld_row  = '0;
        w_ld_col  = '0;
        w_ld_full = 1'b1;
        w_ld_pix  = 4'd0;
      end
      S_SHIFT: begin
        w_ld_col  = r_col + COL_W'(1);
        w_ld_full = 1'b0;
        w_ld_pix  = 4'd0;
      end
      S_WVALID: begin
        w_ld_row  = r_row + ROW_W'(1);
        w_ld_col  = '0;
        w_ld_full = 1'b1;
        w_ld_pix  = 4'd0;
      end
      default: ;
    endcase
  end

  assign w_ld_dr    = w_ld_full ? w_full_dr[w_ld_pix] : w_col_dr[w_ld_pix];
  assign w_ld_dc    = w_ld_full ? w_full_dc[w_ld_pix] : w_col_dc[w_ld_pix];
  assign w_ld_addr  = ADDR_W'(BASE_ADDR + (int'(w_ld_row) + int'(w_ld_dr)) * IMG_W
                              + int'(w_ld_col) + int'(w_ld_dc));
  assign w_cur_slot = r_full ? w_full_slot[r_pix] : w_col_slot[r_pix];
  assign w_last_pix = r_full ? (r_pix == 4'd8) : (r_pix == 4'd2);
  assign w_last_col = (r_col == COL_W'(IMG_W - 3));
  assign w_last_row = (r_row == ROW_W'(IMG_H - 3));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_row          <= '0;
      r_col          <= '0;
      r_pix          <= '0;
      r_full         <= 1'b0;
      r_mem_req      <= 1'b0;
      r_mem_addr     <= '0;
      r_start_read   <= 1'b0;
      r_data_r       <= '0;
      r_slot         <= '0;
      r_start_shift  <= 1'b0;
      r_shift_direc  <= 2'b00;
      r_window_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_frame_done   <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_busy     <= 1'b1;
            r_row      <= '0;
            r_col      <= '0;
            r_full     <= 1'b1;
            r_pix      <= 4'd0;
            r_mem_req  <= 1'b1;
            r_mem_addr <= w_ld_addr;
            r_state    <= S_MREQ;
          end
        end
        S_MREQ: begin
          if (mem_ready) begin
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_start_read <= 1'b1;
            r_data_r     <= mem_rdata;
            r_slot       <= w_cur_slot;
            r_state      <= S_WBWR;
          end
        end
        S_WBWR: begin
          if (read_done) begin
            r_start_read <= 1'b0;
            r_data_r     <= '0;
            r_slot       <= '0;
            if (w_last_pix) begin
              r_window_valid <= 1'b1;
              r_state        <= S_WVALID;
            end else begin
              r_pix      <= r_pix + 4'd1;
              r_mem_req  <= 1'b1;
              r_mem_addr <= w_ld_addr;
              r_state    <= S_MREQ;
            end
          end
        end
        S_WVALID: begin
          if (window_ack) begin
            r_window_valid <= 1'b0;
            if (!w_last_col) begin
              r_start_shift <= 1'b1;
              r_shift_direc <= 2'b01;
              r_state       <= S_SHIFT;
            end else if (!w_last_row) begin
              r_row      <= r_row + ROW_W'(1);
              r_col      <= '0;
              r_full     <= 1'b1;
              r_pix      <= 4'd0;
              r_mem_req  <= 1'b1;
              r_mem_addr <= w_ld_addr;
              r_state    <= S_MREQ;
            end else begin
              r_frame_done <= 1'b1;
              r_busy       <= 1'b0;
              r_state      <= S_DONE;
            end
          end
        end
        S_SHIFT: begin
          // After a left shift only the right column (slots 8,5,2) needs new pixels.
          if (shift_done) begin
            r_start_shift <= 1'b0;
            r_shift_direc <= 2'b00;
            r_col         <= r_col + COL_W'(1);
            r_full        <= 1'b0;
            r_pix         <= 4'd0;
            r_mem_req     <= 1'b1;
            r_mem_addr    <= w_ld_addr;
            r_state       <= S_MREQ;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_req      = r_mem_req;
  assign mem_addr     = r_mem_addr;
  assign start_read   = r_start_read;
  assign data_r       = r_data_r;
  assign slot         = r_slot;
  assign start_shift  = r_start_shift;
  assign shift_direc  = r_shift_direc;
  assign window_valid = r_window_valid;
  assign busy         = r_busy;
  assign frame_done   = r_frame_done;

endmodule

// File: tb/tb_window_fetch_ctrl.sv
// Randomised bench for window_fetch_ctrl: SRAM, window-buffer and consumer models
// plus a transaction-order reference built from the raster/load-order rules.
`timescale 1ns/1ps
module tb_window_fetch_ctrl;
  localparam int W = 4, H = 4, AW = 16, BASE = 0;
  localparam int EV_REQ = 0, EV_WR = 1, EV_SHIFT = 2, EV_WIN = 3, EV_DONE = 4;

  logic clk = 1'b0;
  logic rst, start, mem_req, mem_ready, start_read, read_done;
  logic start_shift, shift_done, window_valid, window_ack, busy, frame_done;
  logic [AW-1:0] mem_addr;
  logic [7:0] mem_rdata, data_r;
  logic [3:0] slot;
  logic [1:0] shift_direc;

  always #5 clk = ~clk;

  window_fetch_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .start_read(start_read), .data_r(data_r), .slot(slot), .read_done(read_done),
    .start_shift(start_shift), .shift_direc(shift_direc), .shift_done(shift_done),
    .window_valid(window_valid), .window_ack(window_ack), .busy(busy), .frame_done(frame_done)
  );

  typedef struct { int kind; int a; int b; } ev_t;
  ev_t exp_q[$];
  int obs_addr[$];
  int obs_slot[$];
  int checks = 0;
  int errors = 0;
  logic [7:0] img [256];
  logic [7:0] wbuf [9];
  logic [7:0] last_rdata = 8'd0;
  int mem_dly = 0, rd_dly = 0, sh_dly = 0, ack_dly = 0;
  bit spur = 1'b0;
  int win_cnt = 0;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int px_addr(int r, int c);
    return (BASE + r * W + c) & 32'h0000FFFF;
  endfunction

  function automatic int pick(int d);
    return (d < 0) ? int'($urandom_range(0, 4)) : d;
  endfunction

  function automatic void push_ev(int k, int a, int b);
    ev_t e;
    e.kind = k; e.a = a; e.b = b;
    exp_q.push_back(e);
  endfunction

  // Expected transaction order of one frame, straight from the raster/load-order rules.
  function automatic void build_frame();
    exp_q.delete();
    for (int r = 0; r <= H - 3; r++) begin
      for (int c = 0; c <= W - 3; c++) begin
        if (c == 0) begin
          for (int k = 0; k < 9; k++) begin
            push_ev(EV_REQ, px_addr(r + 2 - k / 3, c + k % 3), 0);
            push_ev(EV_WR, 3 * (2 - k / 3) + k % 3, 0);
          end
        end else begin
          push_ev(EV_SHIFT, 0, 0);
          for (int dr = 2; dr >= 0; dr--) begin
            push_ev(EV_REQ, px_addr(r + dr, c + 2), 0);
            push_ev(EV_WR, 3 * dr + 2, 0);
          end
        end
        push_ev(EV_WIN, r, c);
      end
    end
    push_ev(EV_DONE, 0, 0);
  endfunction

  task automatic take(int kind, string nm, output ev_t e, output bit ok);
    checks++;
    ok = 1'b0;
    e.kind = -1; e.a = 0; e.b = 0;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: got event kind %0d required none at %0t", nm, kind, $time);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind) begin
        errors++;
        $display("FAIL %s: got event kind %0d required kind %0d at %0t", nm, kind, e.kind, $time);
      end else ok = 1'b1;
    end
  endtask

  // SRAM, window buffer and consumer responders; inputs change on the falling edge.
  initial begin : resp
    int mw = -1, rw = -1, sw = -1, aw = -1;
    mem_ready = 0; mem_rdata = 0; read_done = 0; shift_done = 0; window_ack = 0;
    for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
    for (int i = 0; i < 9; i++) wbuf[i] = 8'd0;
    forever begin
      @(negedge clk);
      mem_ready = 0; read_done = 0; shift_done = 0; window_ack = 0;
      mem_rdata = 8'($urandom);
      if (mem_req) begin
        if (mw < 0) mw = pick(mem_dly);
        if (mw == 0) begin
          mem_ready = 1; mem_rdata = img[mem_addr[7:0]]; last_rdata = mem_rdata; mw = -1;
        end else mw--;
      end else begin
        mw = -1;
        if (spur && $urandom_range(0, 3) == 0) mem_ready = 1;
      end
      if (start_read) begin
        if (rw < 0) rw = pick(rd_dly);
        if (rw == 0) begin
          read_done = 1; wbuf[slot] = data_r; rw = -1;
        end else rw--;
      end else begin
        rw = -1;
        if (spur && $urandom_range(0, 3) == 0) read_done = 1;
      end
      if (start_shift) begin
        if (sw < 0) sw = pick(sh_dly);
        if (sw == 0) begin
          shift_done = 1; sw = -1;
          for (int r = 0; r < 3; r++) begin
            wbuf[3 * r] = wbuf[3 * r + 1];
            wbuf[3 * r + 1] = wbuf[3 * r + 2];
          end
        end else sw--;
      end else begin
        sw = -1;
        if (spur && $urandom_range(0, 3) == 0) shift_done = 1;
      end
      if (window_valid) begin
        if (aw < 0) aw = pick(ack_dly);
        if (aw == 0) begin
          window_ack = 1; aw = -1;
        end else aw--;
      end else begin
        aw = -1;
        if (spur && $urandom_range(0, 3) == 0) window_ack = 1;
      end
    end
  end

  // Per-cycle compare: handshake rules, reset state and transaction order.
  initial begin : cmp
    logic p_mreq = 0, p_sr = 0, p_ss = 0, p_wv = 0, p_busy = 0, p_fd = 0;
    logic [AW-1:0] p_addr = '0;
    logic [7:0] p_data = '0;
    logic [3:0] p_slot = '0;
    ev_t e;
    bit ok;
    int nnew, hs;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        exp_q.delete();
        chk("rst_ctrl", int'({mem_req, start_read, start_shift, shift_direc, window_valid,
                              busy, frame_done, slot}), 0);
        chk("rst_addr", int'(mem_addr), 0);
        chk("rst_data", int'(data_r), 0);
      end else begin
        nnew = 0; hs = 0;
        chk("strobe_excl", int'(mem_req) + int'(start_read) + int'(start_shift) <= 1, 1);
        chk("shift_direc", int'(shift_direc), start_shift ? 1 : 0);
        if (mem_req || start_read || start_shift || window_valid) chk("busy_active", busy, 1);
        if (p_mreq) begin
          if (mem_ready) begin
            chk("mreq_drop", mem_req, 0); chk("sr_after_ready", start_read, 1); hs = 1;
          end else begin
            chk("mreq_hold", mem_req, 1); chk("addr_hold", int'(mem_addr), int'(p_addr));
          end
        end
        if (p_sr) begin
          if (read_done) begin
            chk("sr_drop", start_read, 0); hs = 1;
          end else begin
            chk("sr_hold", start_read, 1); chk("data_hold", data_r, p_data);
            chk("slot_hold", slot, p_slot);
          end
        end
        if (p_ss) begin
          if (shift_done) begin
            chk("ss_drop", start_shift, 0); hs = 1;
          end else chk("ss_hold", start_shift, 1);
        end
        if (p_wv) begin
          if (window_ack) begin
            chk("wv_drop", window_valid, 0); hs = 1;
          end else chk("wv_hold", window_valid, 1);
        end
        if (p_fd) chk("fd_pulse", frame_done, 0);
        if (!p_busy && !p_fd) begin
          if (start) begin
            chk("start_busy", busy, 1); hs = 1;
          end else begin
            chk("idle_busy", busy, 0); chk("idle_mreq", mem_req, 0);
          end
        end
        if (mem_req && !p_mreq) begin
          take(EV_REQ, "ev_req", e, ok); nnew++;
          obs_addr.push_back(int'(mem_addr));
          if (ok) chk("mem_addr", int'(mem_addr), e.a);
        end
        if (start_read && !p_sr) begin
          take(EV_WR, "ev_wr", e, ok); nnew++;
          obs_slot.push_back(int'(slot));
          if (ok) chk("slot", slot, e.a);
          chk("data_r", data_r, last_rdata);
        end
        if (start_shift && !p_ss) begin
          take(EV_SHIFT, "ev_shift", e, ok); nnew++;
        end
        if (window_valid && !p_wv) begin
          take(EV_WIN, "ev_win", e, ok); nnew++; win_cnt++;
          if (ok) for (int s = 0; s < 9; s++)
            chk("win_pixel", wbuf[s], img[px_addr(e.a + s / 3, e.b + s % 3) & 255]);
        end
        if (frame_done && !p_fd) begin
          take(EV_DONE, "ev_done", e, ok); nnew++;
          chk("done_busy", busy, 0);
          chk("win_count", win_cnt, (W - 2) * (H - 2));
        end
        if (hs != 0) chk("next_step", nnew, 1);
      end
      p_mreq = mem_req; p_sr = start_read; p_ss = start_shift; p_wv = window_valid;
      p_busy = busy; p_fd = frame_done; p_addr = mem_addr; p_data = data_r; p_slot = slot;
    end
  end

  task automatic begin_frame(int md, int rd, int sd, int ad, bit sp);
    mem_dly = md; rd_dly = rd; sh_dly = sd; ack_dly = ad; spur = sp;
    obs_addr.delete(); obs_slot.delete(); win_cnt = 0;
    build_frame();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
  endtask

  task automatic run_frame(int md, int rd, int sd, int ad, bit sp);
    int n;
    begin_frame(md, rd, sd, ad, sp);
    n = 0;
    while (!frame_done && n < 4000) begin @(negedge clk); n++; end
    checks++;
    if (!frame_done) begin
      errors++;
      $display("FAIL frame_timeout: frame_done=%0d after %0d cycles, required 1", frame_done, n);
      rst = 1; @(negedge clk); @(negedge clk); rst = 0;
    end
    repeat (2) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("frame md=%0d rd=%0d sd=%0d ad=%0d spur=%0d windows=%0d requests=%0d",
             md, rd, sd, ad, sp, win_cnt, obs_addr.size());
  endtask

  int lit_a[24] = '{8, 9, 10, 4, 5, 6, 0, 1, 2, 11, 7, 3,
                    12, 13, 14, 8, 9, 10, 4, 5, 6, 15, 11, 7};
  int lit_s[24] = '{6, 7, 8, 3, 4, 5, 0, 1, 2, 8, 5, 2,
                    6, 7, 8, 3, 4, 5, 0, 1, 2, 8, 5, 2};

  initial begin : main
    int n;
    rst = 1; start = 1;
    repeat (3) @(negedge clk);
    start = 0;
    @(negedge clk); rst = 0;
    repeat (6) @(negedge clk);

    run_frame(0, 0, 0, 0, 0);
    chk("obs_len", obs_addr.size(), 24);
    for (int i = 0; i < 24; i++) begin
      if (i < obs_addr.size()) chk("lit_addr", obs_addr[i], lit_a[i]);
      if (i < obs_slot.size()) chk("lit_slot", obs_slot[i], lit_s[i]);
    end

    run_frame(3, 2, 1, 2, 0);
    run_frame(-1, -1, -1, -1, 1);
    run_frame(-1, -1, -1, -1, 1);

    // Reset while a shift command is outstanding.
    begin_frame(0, 0, 6, 1, 0);
    n = 0;
    while (!start_shift && n < 500) begin @(negedge clk); n++; end
    chk("shift_reached", start_shift, 1);
    rst = 1;
    @(negedge clk); rst = 0; spur = 1;
    repeat (20) @(negedge clk);
    $display("reset during shift applied, idle for 20 cycles");

    run_frame(-1, -1, -1, -1, 1);
    chk("restart_len", obs_addr.size(), 24);
    if (obs_addr.size() > 0) chk("restart_addr0", obs_addr[0], 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
